// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider for the DDS system.
// Divides clk by any N >= 2, producing a registered square wave clk_div
// (floor(N/2) cycles high, the remainder low) and a one-cycle tick at
// every period start. A new divisor is staged as pending and becomes
// active glitch-free at the next period boundary, or at once while idle.
// Optional build macro DIV_ODD_DUTY50_EN: for odd N, OR a negedge-delayed
// copy of the high phase into clk_div, giving an exact 50% duty cycle.
module clk_div_prog #(
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] DIV_DEFAULT = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_div,
  output logic             tick,
  output logic             div_ack
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;

  logic [CNT_W-1:0] div_san;
  logic [CNT_W-1:0] half;
  logic             wrap;
  logic             apply;

  // Next-state: count through the period, derive outputs, stage and apply divisors
  always_comb begin
    div_san    = (div_val < TWO) ? TWO : div_val;
    half       = div_act_q >> 1;
    wrap       = (cnt_q == (div_act_q - ONE));
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    clk_div_d  = clk_div_q;
    tick_d     = tick_q;
    ack_d      = 1'b0;
    apply      = 1'b0;

    if (en) begin
      cnt_d     = wrap ? '0 : (cnt_q + ONE);
      clk_div_d = (cnt_q < half);
      tick_d    = (cnt_q == '0);
      apply     = wrap & pend_q;
    end else begin
      // Idle: no period in progress, so a pending divisor can go live now
      cnt_d     = '0;
      clk_div_d = 1'b0;
      tick_d    = 1'b0;
      apply     = pend_q;
    end

    if (apply) begin
      div_act_d = div_pend_q;
      pend_d    = 1'b0;
      ack_d     = 1'b1;
    end

    // A load on the apply edge stages the new value for the following wrap
    if (div_load) begin
      div_pend_d = div_san;
      pend_d     = 1'b1;
    end
  end

  // State and registered outputs; asynchronous reset discards any pending load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_act_q  <= DIV_DEFAULT;
      div_pend_q <= DIV_DEFAULT;
      pend_q     <= 1'b0;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
    end
  end

`ifdef DIV_ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle delayed copy of the high phase, used only for odd divisors
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= clk_div_q & div_act_q[0];
    end
  end

  assign clk_div = clk_div_q | neg_q;
`else
  assign clk_div = clk_div_q;
`endif

  assign tick    = tick_q;
  assign div_ack = ack_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: randomized plus scenario stimulus, scoreboard
// fed by a period-level reference model, monitor compares every clock.
module tb_clk_div_prog;

  localparam int unsigned      CNT_W = 16;
  localparam logic [CNT_W-1:0] DEF   = 16'd4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             clk_div;
  logic             tick;
  logic             div_ack;

  clk_div_prog #(.CNT_W(CNT_W), .DIV_DEFAULT(DEF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_div  (clk_div),
    .tick     (tick),
    .div_ack  (div_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {clk_div, tick, div_ack} after each rising edge
  logic [2:0] exp_q[$];

  // Reference model: period-level view of the output waveform
  int unsigned m_act;
  int unsigned m_pend;
  bit          m_pendv;
  logic [1:0]  wave_q[$];   // remaining {clk_div, tick} samples of the current period
  bit          m_prev_q;
  bit          m_prev_odd;

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got {clk_div,tick,ack}=%b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act      = DEF;
    m_pend     = DEF;
    m_pendv    = 1'b0;
    wave_q.delete();
    m_prev_q   = 1'b0;
    m_prev_odd = 1'b0;
  endtask

  function automatic logic [2:0] model_step(input bit e, input bit ld, input int unsigned v);
    bit q, t, a, co;
    logic [1:0] s;
    q = 1'b0; t = 1'b0; a = 1'b0;
    if (e) begin
      if (wave_q.size() == 0)
        for (int i = 0; i < int'(m_act); i++)
          wave_q.push_back({(i < int'(m_act / 2)), (i == 0)});
      s = wave_q.pop_front();
      q = s[1];
      t = s[0];
      if (wave_q.size() == 0 && m_pendv) begin
        m_act = m_pend; m_pendv = 1'b0; a = 1'b1;
      end
    end else begin
      wave_q.delete();
      if (m_pendv) begin
        m_act = m_pend; m_pendv = 1'b0; a = 1'b1;
      end
    end
    if (ld) begin
      m_pend  = (v < 2) ? 2 : v;
      m_pendv = 1'b1;
    end
    co = q;
`ifdef DIV_ODD_DUTY50_EN
    co = q | (m_prev_q & m_prev_odd);
`endif
    m_prev_q   = q;
    m_prev_odd = (m_act % 2) == 1;
    return {co, t, a};
  endfunction

  // Drive one cycle's inputs at the falling edge and queue the expected result
  task automatic cycle(input bit e, input bit ld, input int unsigned v);
    @(negedge clk);
    en       = e;
    div_load = ld;
    div_val  = CNT_W'(v);
    exp_q.push_back(model_step(e, ld, v));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0);
  endtask

  // Monitor: compare every rising edge while out of reset
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {clk_div, tick, div_ack}, e);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    model_reset();
    #12;
    check("reset_state", {clk_div, tick, div_ack}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Default divisor 4
    run(12);

    // Odd N = 5 loaded while idle
    cycle(1'b0, 1'b1, 5);
    cycle(1'b0, 1'b0, 0);
    run(15);

    // Mid-period reload: 6 running, load 10 at cnt = 2
    cycle(1'b0, 1'b1, 6);
    cycle(1'b0, 1'b0, 0);
    run(2);
    cycle(1'b1, 1'b1, 10);
    run(25);

    // Last load wins and is clamped to 2
    run(2);
    cycle(1'b1, 1'b1, 8);
    cycle(1'b1, 1'b1, 1);
    run(14);

    // Load collision on the wrap edge: 7 pending, load 12
    cycle(1'b0, 1'b1, 3);
    cycle(1'b0, 1'b0, 0);
    run(1);
    cycle(1'b1, 1'b1, 7);
    guard = 0;
    while (wave_q.size() != 1 && guard < 50) begin
      run(1);
      guard++;
    end
    cycle(1'b1, 1'b1, 12);
    run(30);

    // Enable abort at cnt = 3 of N = 8, then a fresh period
    cycle(1'b0, 1'b1, 8);
    cycle(1'b0, 1'b0, 0);
    run(3);
    cycle(1'b0, 1'b0, 0);
    run(18);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit e, ld;
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 19) == 0);
      cycle(e, ld, $urandom_range(0, 17));
    end

    // Reset mid-high-phase with a pending load outstanding
    cycle(1'b0, 1'b1, 9);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 11);
    run(1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {clk_div, tick, div_ack}, 3'b000);
    model_reset();
    en = 1'b0;
    div_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held_reset", {clk_div, tick, div_ack}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    run(16);

    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider for the DDS system: the parametrised successor of the fixed even divider. It derives a slow clock-enable-style square wave `clk_div` and a one-cycle `tick` from the system clock by any ratio N ≥ 2, even or odd. The divisor can be reloaded at run time, and a new value takes effect glitch-free at the next output-period boundary. It sits between the system clock and the DDS phase-accumulator / DAC sample-rate logic.

## Interface
- `CNT_W`, 32, width of divisor and internal counter.
- `DIV_DEFAULT`, 50_000_000, active divisor after reset (must be ≥ 2).

- `clk`  input  1  system clock; all logic on rising edge, except the optional negedge flop under `DIV_ODD_DUTY50_EN`.
- `rst_n`  input  1  asynchronous active-low reset.
- `en`  input  1  run enable; low holds the divider idle.
- `div_val`  input  CNT_W  requested divisor N.
- `div_load`  input  1  one-cycle strobe; captures `div_val` as pending.
- `clk_div`  output  1  divided square wave, registered.
- `tick`  output  1  one-cycle pulse at each `clk_div` period start.
- `div_ack`  output  1  one-cycle pulse when a pending divisor becomes active.

## Operation
- Registers:
  - `cnt` [CNT_W-1:0]
  - `div_act` (reset `DIV_DEFAULT`)
  - `div_pend`
  - `pend` flag
- Divisor sanitising: `div_val` of 0 or 1 is stored as 2. No other range check.
- Load: `div_load` = 1 writes the sanitised value to `div_pend` and sets `pend`. A later load before apply overwrites the earlier one; the last value wins.
- High length H = floor(N/2); low length N − H. For odd N the high phase is one cycle shorter (unless the macro is set).
- With `en` = 1, each edge:
  - `cnt` ← 0 when `cnt` == `div_act` − 1, else `cnt` + 1.
  - `clk_div` ← (`cnt` < H).
  - `tick` ← (`cnt` == 0).
- Apply point (wrap edge, `cnt` == `div_act` − 1, `en` = 1): if `pend`, then `div_act` ← `div_pend`, `pend` cleared, `div_ack` ← 1. The new N governs the very next period.
- Load and wrap on the same edge:
  - The previously pending value (if any) is applied.
  - The new `div_val` becomes pending for the following wrap.
- `en` = 0:
  - `cnt` ← 0, `clk_div` ← 0, `tick` ← 0.
  - A pending value is applied immediately (with `div_ack`), because no period is in progress.
- The `en` rising edge starts a fresh period from `cnt` = 0.
- The `en` falling edge mid-period truncates the period; no glitch shorter than one clk cycle is produced.

## Timing
- Reset values: `cnt` = 0, `clk_div` = 0, `tick` = 0, `div_ack` = 0, `pend` = 0, `div_act` = `DIV_DEFAULT`, `div_pend` = `DIV_DEFAULT`.
- Latency:
  - First edge with `en` = 1 (`cnt` = 0): after it, `clk_div` = 1 and `tick` = 1.
  - `clk_div` and `tick` lag `cnt` by one cycle.
- Period: exactly `div_act` clk cycles. `tick` recurs every N cycles.
- `div_ack` is asserted on the same edge at which `div_act` changes.
- Reset mid-operation clears everything asynchronously; pending loads are discarded.

## Configuration
- `DIV_ODD_DUTY50_EN` defined, odd N:
  - An extra negedge-clocked copy of the high phase is ORed into `clk_div`.
  - This stretches the high phase by half a clk period, giving exactly 50% duty.
  - `clk_div` is then not purely posedge-registered.
  - Even N is unaffected.
- Not defined: odd N gives H high / H+1 low cycles. The output is purely posedge-registered with no negedge logic.

## Test plan
- **Reset default, even N**: release reset, `en` = 1, `DIV_DEFAULT` = 4 -> `clk_div` pattern 1,1,0,0 repeating; `tick` every 4 cycles; `div_ack` never.
- **Odd N, macro off**: load 5 while `en` = 0 -> `div_ack` next edge; enable -> `clk_div` 2 high / 3 low; period 5.
- **Odd N, macro on**: N = 5 -> measured high time 2.5 clk periods, low time 2.5; period 5.
- **Mid-period reload**: N = 6 running; load 10 at `cnt` = 2 -> the current 6-cycle period completes; `div_ack` at the wrap; next period is 10 (5 high / 5 low).
- **Load collision and sanitising**:
  - Load 8 then load 1 before wrap -> active becomes 2 (last wins, clamped).
  - Load 12 on the wrap edge with 7 pending -> 7 applies now; 12 applies at the next wrap.
- **Enable and reset abort**:
  - Drop `en` at `cnt` = 3 of N = 8 -> `clk_div` = 0 next edge, `cnt` = 0.
  - Re-enable -> full fresh period.
  - Assert `rst_n` low mid-high-phase -> outputs 0 immediately, pending discarded.
